msb_incrementer_pipe: RTL and testbench

- Pipelined, parametrised successor of the combinational FMA high-part incrementer.
- Takes the upper (aligned addend) mantissa slice and the low-adder carries, and produces:
  - the incremented sum for effective addition;
  - the complement/decrement sum for effective subtraction;
  - a selected result.
- Sits between the low-part CSA/adder stage and normalisation in the FMA datapath.
- Adds valid/ready flow control, a configurable register depth, flush, carry/borrow flags and a saturating wrap-event counter.

---
 rtl/fma_pkg.sv | 27 ++
 rtl/msb_inc_core.sv | 35 +++
 rtl/msb_incrementer_pipe.sv | 140 ++++++++++++++
 tb/tb_msb_incrementer_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// Shared FMA datapath definitions: mantissa width default, high-slice width
// derivation and the per-stage payload types of the high-part incrementer.
package fma_pkg;

  localparam int unsigned MANT_DEFAULT = 23;

  // High slice carries the mantissa plus guard/alignment bits.
  function automatic int unsigned high_width(input int unsigned mant);
    return mant + 4;
  endfunction

  localparam int unsigned W_DEF = high_width(MANT_DEFAULT);

  typedef struct packed {
    logic carry;
    logic borrow;
    logic eff_sub;
  } stage_flags_t;

  // Stage payload at the default width; parametrised users rebuild it locally.
  typedef struct packed {
    logic [W_DEF-1:0] sum;
    logic [W_DEF-1:0] sum_inv;
    stage_flags_t     flags;
  } stage_t;

endpackage

// File: rtl/msb_inc_core.sv
// Combinational high-part arithmetic: increment for effective addition and
// complement/decrement for effective subtraction, both evaluated at W+1 bits.
module msb_inc_core
  import fma_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic [W-1:0]  a_high_i,
  input  logic          low_carry_i,
  input  logic          low_carry_inv_i,
  input  logic          eff_sub_i,
  output logic [W-1:0]  sum_o,
  output logic [W-1:0]  sum_inv_o,
  output stage_flags_t  flags_o
);

  logic [W-1:0] a_inv;
  logic [W:0]   add_ext;
  logic [W:0]   dec_ext;

  // Both paths in one pass; the top bit of each W+1 result is the wrap flag.
  always_comb begin
    a_inv   = ~a_high_i;
    add_ext = {1'b0, a_high_i} + {{W{1'b0}}, low_carry_i};
    // Without a low inverted carry the complement is decremented; borrows only at ~a == 0.
    dec_ext = {1'b0, a_inv} - {{W{1'b0}}, ~low_carry_inv_i};

    sum_o           = add_ext[W-1:0];
    sum_inv_o       = dec_ext[W-1:0];
    flags_o.carry   = add_ext[W];
    flags_o.borrow  = dec_ext[W];
    flags_o.eff_sub = eff_sub_i;
  end

endmodule

// File: rtl/msb_incrementer_pipe.sv
// Pipelined FMA high-part incrementer with valid/ready flow control, flush,
// carry/borrow flags and a saturating wrap-event counter.
module msb_incrementer_pipe
  import fma_pkg::*;
#(
  parameter int unsigned PARM_MANT   = MANT_DEFAULT,
  parameter int unsigned PARM_STAGES = 2,  // legal 1..3, equals latency
  parameter int unsigned PARM_CNT_W  = 8,
  localparam int unsigned W          = high_width(PARM_MANT)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  low_carry_i,
  input  logic                  low_carry_inv_i,
  input  logic                  eff_sub_i,
  input  logic [W-1:0]          a_high_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [W-1:0]          high_sum_o,
  output logic [W-1:0]          high_sum_inv_o,
  output logic [W-1:0]          res_o,
  output logic                  high_carry_o,
  output logic                  high_borrow_o,
  output logic [PARM_CNT_W-1:0] wrap_cnt_o,
  input  logic                  cnt_clr_i
);

  localparam int unsigned LAST = PARM_STAGES - 1;

  typedef struct packed {
    logic [W-1:0] sum;
    logic [W-1:0] sum_inv;
    stage_flags_t flags;
  } payload_t;

  payload_t                core_data;
  payload_t                data_q    [PARM_STAGES];
  payload_t                src_data  [PARM_STAGES];
  logic                    src_valid [PARM_STAGES];
  logic [PARM_STAGES-1:0]  valid_q;
  logic [PARM_STAGES-1:0]  adv;
  logic                    all_full;
  logic                    handshake;
  logic                    wrap_inc;
  logic [PARM_CNT_W-1:0]   cnt_q;
  logic [PARM_CNT_W-1:0]   cnt_d;

  msb_inc_core #(
    .W (W)
  ) u_core (
    .a_high_i        (a_high_i),
    .low_carry_i     (low_carry_i),
    .low_carry_inv_i (low_carry_inv_i),
    .eff_sub_i       (eff_sub_i),
    .sum_o           (core_data.sum),
    .sum_inv_o       (core_data.sum_inv),
    .flags_o         (core_data.flags)
  );

  // A stage advances unless it and every stage after it are full while ready_i is low.
  always_comb begin
    adv      = '0;
    all_full = 1'b1;
    for (int s = 0; s < int'(PARM_STAGES); s++) begin
      all_full = 1'b1;
      for (int k = s; k < int'(PARM_STAGES); k++) begin
        all_full = all_full & valid_q[k];
      end
      adv[s] = ready_i | ~all_full;
    end
  end

  // Source of each stage: the core for stage 1, the previous stage otherwise.
  always_comb begin
    src_valid[0] = valid_i;
    src_data[0]  = core_data;
    for (int s = 1; s < int'(PARM_STAGES); s++) begin
      src_valid[s] = valid_q[s-1];
      src_data[s]  = data_q[s-1];
    end
  end

  // Stage registers; payload only loads with a valid beat so held outputs stay put.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int s = 0; s < int'(PARM_STAGES); s++) begin
        data_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < int'(PARM_STAGES); s++) begin
        if (flush_i) begin
          valid_q[s] <= 1'b0;
        end else if (adv[s]) begin
          valid_q[s] <= src_valid[s];
          if (src_valid[s]) begin
            data_q[s] <= src_data[s];
          end
        end
      end
    end
  end

  // Saturating wrap counter; clear takes priority over a coincident increment.
  always_comb begin
    handshake = valid_q[LAST] & ready_i;
    wrap_inc  = handshake & (data_q[LAST].flags.carry | data_q[LAST].flags.borrow);
    cnt_d     = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (wrap_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + PARM_CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Outputs come straight from the last stage.
  always_comb begin
    ready_o        = adv[0];
    valid_o        = valid_q[LAST];
    high_sum_o     = data_q[LAST].sum;
    high_sum_inv_o = data_q[LAST].sum_inv;
    res_o          = data_q[LAST].flags.eff_sub ? data_q[LAST].sum_inv : data_q[LAST].sum;
    high_carry_o   = data_q[LAST].flags.carry;
    high_borrow_o  = data_q[LAST].flags.borrow;
    wrap_cnt_o     = cnt_q;
  end

endmodule

// File: tb/tb_msb_incrementer_pipe.sv
// Directed self-checking bench for msb_incrementer_pipe (default parameters, W=27).
module tb_msb_incrementer_pipe;

  localparam int unsigned W     = 27;
  localparam int unsigned CNT_W = 8;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic             low_carry_i;
  logic             low_carry_inv_i;
  logic             eff_sub_i;
  logic [W-1:0]     a_high_i;
  logic             valid_o;
  logic             ready_i;
  logic [W-1:0]     high_sum_o;
  logic [W-1:0]     high_sum_inv_o;
  logic [W-1:0]     res_o;
  logic             high_carry_o;
  logic             high_borrow_o;
  logic [CNT_W-1:0] wrap_cnt_o;
  logic             cnt_clr_i;

  int n_checks = 0;
  int n_err    = 0;

  msb_incrementer_pipe #(
    .PARM_MANT   (23),
    .PARM_STAGES (2),
    .PARM_CNT_W  (CNT_W)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .low_carry_i     (low_carry_i),
    .low_carry_inv_i (low_carry_inv_i),
    .eff_sub_i       (eff_sub_i),
    .a_high_i        (a_high_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .high_sum_o      (high_sum_o),
    .high_sum_inv_o  (high_sum_inv_o),
    .res_o           (res_o),
    .high_carry_o    (high_carry_o),
    .high_borrow_o   (high_borrow_o),
    .wrap_cnt_o      (wrap_cnt_o),
    .cnt_clr_i       (cnt_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic lc, input logic lci,
                       input logic es);
    valid_i         = v;
    a_high_i        = a;
    low_carry_i     = lc;
    low_carry_inv_i = lci;
    eff_sub_i       = es;
  endtask

  initial begin
    rst_ni    = 1'b0;
    flush_i   = 1'b0;
    ready_i   = 1'b1;
    cnt_clr_i = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("rst_valid_o", 32'(valid_o), 32'h0);
    chk("rst_res", 32'(res_o), 32'h0);
    chk("rst_cnt", 32'(wrap_cnt_o), 32'h0);
    #9 rst_ni = 1'b1;
    #1;
    chk("rst_ready_o", 32'(ready_o), 32'h1);

    // All-ones slice with carry-in: addition wraps, subtraction borrows.
    tick();
    drive(1'b1, 27'h7FFFFFF, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t1_lat1_valid", 32'(valid_o), 32'h0);
    tick();
    chk("t1_valid", 32'(valid_o), 32'h1);
    chk("t1_sum", 32'(high_sum_o), 32'h0);
    chk("t1_carry", 32'(high_carry_o), 32'h1);
    chk("t1_sum_inv", 32'(high_sum_inv_o), 32'h7FFFFFF);
    chk("t1_borrow", 32'(high_borrow_o), 32'h1);
    chk("t1_res", 32'(res_o), 32'h0);
    tick();
    chk("t1_cnt", 32'(wrap_cnt_o), 32'h1);
    chk("t1_drained", 32'(valid_o), 32'h0);

    // Plain subtraction with inverted carry: complement only.
    drive(1'b1, 27'h0000005, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t2_valid", 32'(valid_o), 32'h1);
    chk("t2_sum", 32'(high_sum_o), 32'h5);
    chk("t2_sum_inv", 32'(high_sum_inv_o), 32'h7FFFFFA);
    chk("t2_res", 32'(res_o), 32'h7FFFFFA);
    chk("t2_carry", 32'(high_carry_o), 32'h0);
    chk("t2_borrow", 32'(high_borrow_o), 32'h0);
    tick();
    chk("t2_cnt", 32'(wrap_cnt_o), 32'h1);

    // Backpressure: four beats, downstream stalls while both stages fill.
    drive(1'b1, 27'h10, 1'b0, 1'b1, 1'b0);
    tick();
    ready_i = 1'b0;
    drive(1'b1, 27'h11, 1'b0, 1'b1, 1'b0);
    #1;
    chk("t3_ready_one_full", 32'(ready_o), 32'h1);
    tick();
    drive(1'b1, 27'h12, 1'b0, 1'b1, 1'b0);
    #1;
    chk("t3_ready_both_full", 32'(ready_o), 32'h0);
    chk("t3_hold0", 32'(res_o), 32'h10);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t3_hold_valid", 32'(valid_o), 32'h1);
      chk("t3_hold_res", 32'(res_o), 32'h10);
      chk("t3_hold_ready", 32'(ready_o), 32'h0);
    end
    ready_i = 1'b1;
    #1;
    chk("t3_ready_release", 32'(ready_o), 32'h1);
    tick();
    drive(1'b1, 27'h13, 1'b0, 1'b1, 1'b0);
    chk("t3_out1", 32'(res_o), 32'h11);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t3_out2", 32'(res_o), 32'h12);
    tick();
    chk("t3_out3", 32'(res_o), 32'h13);
    chk("t3_out3_valid", 32'(valid_o), 32'h1);
    tick();
    chk("t3_empty", 32'(valid_o), 32'h0);

    // Flush with two beats held and a third offered.
    ready_i = 1'b0;
    drive(1'b1, 27'h20, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 27'h21, 1'b0, 1'b1, 1'b0);
    tick();
    chk("t4_pre_valid", 32'(valid_o), 32'h1);
    drive(1'b1, 27'h22, 1'b0, 1'b1, 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    ready_i = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_flushed", 32'(valid_o), 32'h0);
      tick();
    end
    drive(1'b1, 27'h30, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t4_lat1", 32'(valid_o), 32'h0);
    tick();
    chk("t4_lat2_valid", 32'(valid_o), 32'h1);
    chk("t4_lat2_res", 32'(res_o), 32'h30);
    chk("t4_cnt_kept", 32'(wrap_cnt_o), 32'h1);
    tick();

    // 300 wrapping beats on top of the existing count of 1: saturate at 255.
    drive(1'b1, 27'h7FFFFFF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("t5_saturated", 32'(wrap_cnt_o), 32'hFF);
    // Clear coinciding with a wrapping handshake.
    drive(1'b1, 27'h7FFFFFF, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t5_pending_wrap", 32'(high_carry_o & valid_o), 32'h1);
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    chk("t5_clear_wins", 32'(wrap_cnt_o), 32'h0);
    drive(1'b1, 27'h7FFFFFF, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("t5_recount", 32'(wrap_cnt_o), 32'h1);

    // Asynchronous reset while a beat is held at the output.
    ready_i = 1'b0;
    drive(1'b1, 27'h7FFFFFF, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t6_pre_res", 32'(res_o), 32'h7FFFFFF);
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_valid", 32'(valid_o), 32'h0);
    chk("t6_res", 32'(res_o), 32'h0);
    chk("t6_sum_inv", 32'(high_sum_inv_o), 32'h0);
    chk("t6_carry", 32'(high_carry_o), 32'h0);
    chk("t6_borrow", 32'(high_borrow_o), 32'h0);
    chk("t6_cnt", 32'(wrap_cnt_o), 32'h0);
    #3 rst_ni = 1'b1;
    ready_i = 1'b1;
    #1;
    chk("t6_ready", 32'(ready_o), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_stale", 32'(valid_o), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
